pipe_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the

---
 rtl/pipe_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// pipeline-register control bundles and zero-control bubble constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam int unsigned RA_W_DEF = 5;

  // Zeroed WB/MEM/EX control fields loaded into ID/EX for a bubble
  localparam logic [2:0]  WB_NOP  = '0;
  localparam logic [11:0] MEM_NOP = '0;
  localparam logic [7:0]  EX_NOP  = '0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_we;
  } ctl_t;

  localparam ctl_t CTL_RUN   = 7'b1101011;
  localparam ctl_t CTL_HOLD  = 7'b0000000;
  localparam ctl_t CTL_REDIR = 7'b1111111;
  localparam ctl_t CTL_LDU   = 7'b0001111;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the
// instruction in IF/ID; register $0 never creates a dependency.
module hazard_detect #(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] ifid_rs,
  input  logic [RA_W-1:0] ifid_rt,
  input  logic            ifid_use_rt,
  input  logic            idex_memread,
  input  logic [RA_W-1:0] idex_rt,
  output logic            ldu_hit
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (idex_rt == ifid_rs);
    rt_match = ifid_use_rt && (idex_rt == ifid_rt);
    ldu_hit  = idex_memread && (idex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// redirect flushes, data-memory wait states with a watchdog, stall statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W     = RA_W_DEF,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  ifid_rs,
  input  logic [RA_W-1:0]  ifid_rt,
  input  logic             ifid_use_rt,
  input  logic             idex_memread,
  input  logic [RA_W-1:0]  idex_rt,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WC_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              ldu_hit;
  ctl_t              ctl;
  ctl_t              ctl_out;

  hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_use_rt  (ifid_use_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ldu_hit      (ldu_hit)
  );

  always_comb begin
    ctl        = CTL_RUN;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          ctl        = CTL_HOLD;
          state_d    = ST_MWAIT;
          wait_cnt_d = WC_W'(1);
        end else if (ex_redirect) begin
          ctl = CTL_REDIR;
        end else if (ldu_hit) begin
          ctl = CTL_LDU;
        end
      end
      ST_MWAIT: begin
        if (mem_ready) begin
          ctl        = CTL_RUN;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          ctl = CTL_HOLD;
          if (wait_cnt_q == WC_W'(WAIT_MAX - 1)) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      ST_ERR: begin
        ctl       = CTL_HOLD;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctl.pc_we && (state_q != ST_ERR) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Controls fall back to free-running values while reset is held so the
  // pipeline registers never see a stale stall or bubble request.
  always_comb begin
    ctl_out = reset ? ctl : CTL_RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    pc_we       = ctl_out.pc_we;
    ifid_we     = ctl_out.ifid_we;
    ifid_flush  = ctl_out.ifid_flush;
    idex_we     = ctl_out.idex_we;
    idex_bubble = ctl_out.idex_bubble;
    exmem_we    = ctl_out.exmem_we;
    memwb_we    = ctl_out.memwb_we;
    mem_err     = mem_err_q;
    state       = state_q;
    stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls/state/stall count
// are queued as stimulus is applied and checked mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RA_W     = 5;
  localparam int unsigned WAIT_MAX = 16;
  localparam int unsigned CNT_W    = 16;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we, mem_err, state}
  localparam logic [9:0] C_NORM   = 10'b1101011_0_00;
  localparam logic [9:0] C_LDU    = 10'b0001111_0_00;
  localparam logic [9:0] C_REDIR  = 10'b1111111_0_00;
  localparam logic [9:0] C_WRUN   = 10'b0000000_0_00;
  localparam logic [9:0] C_WAIT   = 10'b0000000_0_01;
  localparam logic [9:0] C_RESUME = 10'b1101011_0_01;
  localparam logic [9:0] C_ERR    = 10'b0000000_1_10;

  typedef struct packed {
    logic [9:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic [RA_W-1:0]  ifid_rs, ifid_rt, idex_rt;
  logic             ifid_use_rt, idex_memread, ex_redirect, mem_req, mem_ready;
  logic             pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0]       obs;

  assign obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we,
                mem_err, state};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(RA_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_use_rt  (ifid_use_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_we      (idex_we),
    .idex_bubble  (idex_bubble),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .mem_err      (mem_err),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  task automatic drv(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                     input logic use_rt, input logic memrd, input logic [RA_W-1:0] irt,
                     input logic redir, input logic req, input logic rdy,
                     input logic [9:0] ectl, input logic [CNT_W-1:0] ecnt);
    @(negedge clk);
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_use_rt  = use_rt;
    idex_memread = memrd;
    idex_rt      = irt;
    ex_redirect  = redir;
    mem_req      = req;
    mem_ready    = rdy;
    sb.push_back('{ctl: ectl, cnt: ecnt});
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(RA_W'($urandom_range(0, 31)), RA_W'($urandom_range(0, 31)), 1'($urandom),
          1'($urandom), RA_W'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
          1'($urandom), C_NORM, '0);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("FAIL reset_hold[%0d] ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL reset_hold[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.cnt);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv('0, '0, 0, 0, '0, 0, 0, 0, C_NORM, '0);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL reset_release[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drv(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0, C_LDU,  16'd0);
        1: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM, 16'd1);
        2: drv(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, C_NORM, 16'd1);
        default: drv(5'd8, 5'd0, 0, 0, 5'd8, 0, 0, 0, C_NORM, 16'd1);
      endcase
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL load_use[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_rt_compare();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drv(5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 0, C_NORM, 16'd1);
        1: drv(5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 0, C_LDU,  16'd1);
        default: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM, 16'd2);
      endcase
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL rt_compare[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drv(5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0, C_REDIR, 16'd2);
        1: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM,  16'd2);
        default: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_NORM, 16'd2);
      endcase
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL redirect[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_WRUN,   16'd2);
        1: drv(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 0, C_WAIT,   16'd3);
        2: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_WAIT,   16'd4);
        3: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_RESUME, 16'd5);
        default: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM, 16'd5);
      endcase
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL mem_wait[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)
        drv('0, '0, 0, 0, '0, 0, 1, 0, C_WRUN, 16'd5);
      else if (i < 16)
        drv('0, '0, 0, 0, '0, 0, 1, 0, C_WAIT, CNT_W'(5 + i));
      else if (i == 16)
        drv('0, '0, 0, 0, '0, 0, 1, 0, C_ERR, 16'd21);
      else if (i == 17)
        drv('0, '0, 0, 0, '0, 0, 1, 1, C_ERR, 16'd21);
      else
        drv(5'd8, '0, 0, 1, 5'd8, 1, 0, 0, C_ERR, 16'd21);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL timeout[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_reset_recover();
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{ctl: C_NORM, cnt: '0});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.ctl || stall_cnt !== e.cnt) begin
      errors++;
      $display("FAIL reset_mid_err got %b/%0d want %b/%0d", obs, stall_cnt, e.ctl, e.cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM, 16'd0);
        1: drv(5'd4, 5'd7, 1, 1, 5'd7, 0, 0, 0, C_LDU,  16'd0);
        default: drv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM, 16'd1);
      endcase
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL reset_recover[%0d] got %b/%0d want %b/%0d", i, obs, stall_cnt,
                 e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
    ifid_use_rt = 0; idex_memread = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
    test_reset();
    test_load_use();
    test_rt_compare();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_recover();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
